// File: rtl/game_pkg.sv
// Shared definitions for the game round sequencer and the display colour logic.
// The state encoding here is also what the display decodes.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_OVER   = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector with an asynchronous active-low reset.
// RST_VAL=1 suppresses an edge for a level that is already high when reset releases.
module edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= RST_VAL;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer for the slug/bug game: IDLE -> PLAY -> OVER -> IDLE.
// Counts score and game seconds during PLAY and blinks the display during OVER.
module game_sequencer
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int GAME_SECONDS   = 30,
    parameter int FLASH_FRAMES   = 15,
    parameter int MAX_SCORE      = 31
) (
    input  logic       clk,
    input  logic       greset_n,
    input  logic       btnC,
    input  logic       frame,
    input  logic       caught,
    output logic       run,
    output logic [4:0] score,
    output logic [5:0] time_left,
    output logic [1:0] state,
    output logic       score_inc,
    output logic       flash
);

    // One counter serves as frame counter in PLAY and blink counter in OVER.
    localparam int CNT_W = $clog2(max_int(FRAMES_PER_SEC, FLASH_FRAMES));

    localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(FRAMES_PER_SEC - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [4:0]       SCORE_MAX  = 5'(MAX_SCORE);
    localparam logic [5:0]       TIME_INIT  = 6'(GAME_SECONDS);

    state_t           st_q, st_d;
    logic [4:0]       score_q, score_d;
    logic [5:0]       time_q, time_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc_q, inc_d;
    logic             flash_q, flash_d;
    logic             start_edge, catch_edge;

    edge_detect #(.RST_VAL(1'b1)) u_btn_edge (
        .clk   (clk),
        .rst_n (greset_n),
        .d     (btnC),
        .rise  (start_edge)
    );

    edge_detect #(.RST_VAL(1'b1)) u_catch_edge (
        .clk   (clk),
        .rst_n (greset_n),
        .d     (caught),
        .rise  (catch_edge)
    );

    always_ff @(posedge clk or negedge greset_n) begin
        if (!greset_n) begin
            st_q    <= ST_IDLE;
            score_q <= '0;
            time_q  <= TIME_INIT;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            st_q    <= st_d;
            score_q <= score_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        st_d    = st_q;
        score_d = score_q;
        time_d  = time_q;
        cnt_d   = cnt_q;
        inc_d   = 1'b0;
        flash_d = 1'b0;

        unique case (st_q)
            ST_IDLE: begin
                if (start_edge) begin
                    st_d    = ST_PLAY;
                    score_d = '0;
                    time_d  = TIME_INIT;
                    cnt_d   = '0;
                end
            end

            ST_PLAY: begin
                if (catch_edge && (score_q < SCORE_MAX)) begin
                    score_d = score_q + 5'd1;
                    inc_d   = 1'b1;
                end
                if (frame) begin
                    if (cnt_q == SEC_LAST) begin
                        cnt_d  = '0;
                        time_d = time_q - 6'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // A final catch and the final second can land together; both count.
                if ((time_d == 6'd0) || (score_d == SCORE_MAX)) begin
                    st_d    = ST_OVER;
                    cnt_d   = '0;
                    flash_d = 1'b1;
                end
            end

            ST_OVER: begin
                flash_d = flash_q;
                if (start_edge) begin
                    st_d    = ST_IDLE;
                    cnt_d   = '0;
                    flash_d = 1'b0;
                end else if (frame) begin
                    if (cnt_q == FLASH_LAST) begin
                        cnt_d   = '0;
                        flash_d = ~flash_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    assign run       = (st_q == ST_PLAY);
    assign state     = st_q;
    assign score     = score_q;
    assign time_left = time_q;
    assign score_inc = inc_q;
    assign flash     = flash_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small parameters (4 fps, 3 s, blink 2, max 5).
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       greset_n;
    logic       btnC;
    logic       frame;
    logic       caught;
    logic       run;
    logic [4:0] score;
    logic [5:0] time_left;
    logic [1:0] state;
    logic       score_inc;
    logic       flash;

    int errors = 0;
    int checks = 0;
    int inc_count = 0;

    game_sequencer #(
        .FRAMES_PER_SEC (4),
        .GAME_SECONDS   (3),
        .FLASH_FRAMES   (2),
        .MAX_SCORE      (5)
    ) dut (
        .clk       (clk),
        .greset_n  (greset_n),
        .btnC      (btnC),
        .frame     (frame),
        .caught    (caught),
        .run       (run),
        .score     (score),
        .time_left (time_left),
        .state     (state),
        .score_inc (score_inc),
        .flash     (flash)
    );

    always #5 clk = ~clk;

    // Count cycles on which score_inc is high, sampled mid-cycle.
    always @(negedge clk) if (score_inc) inc_count++;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1; tick();
            frame = 1'b0; tick();
        end
    endtask

    task automatic press_btn();
        btnC = 1'b1; tick();
        btnC = 1'b0; tick();
    endtask

    task automatic catch_once();
        caught = 1'b1; tick();
        caught = 1'b0; tick();
    endtask

    localparam logic [7:0] FLASH_SEQ = 8'b1100_1100;

    initial begin
        greset_n = 1'b0;
        btnC     = 1'b0;
        frame    = 1'b0;
        caught   = 1'b0;
        #23;
        check("rst_state", state, 0);
        check("rst_run", run, 0);
        check("rst_score", score, 0);
        check("rst_time", time_left, 3);
        check("rst_inc", score_inc, 0);
        check("rst_flash", flash, 0);

        greset_n = 1'b1;
        tick(2);

        // Start a round and run the clock out.
        btnC = 1'b1; tick();
        check("start_state", state, 1);
        check("start_time", time_left, 3);
        check("start_score", score, 0);
        check("start_run", run, 1);
        btnC = 1'b0; tick();
        pulse_frames(4);
        check("sec1_time", time_left, 2);
        pulse_frames(7);
        check("f11_state", state, 1);
        check("f11_time", time_left, 1);
        pulse_frames(1);
        check("f12_state", state, 2);
        check("f12_run", run, 0);
        check("f12_time", time_left, 0);

        // Blink in OVER: flash value seen at each frame pulse.
        for (int i = 0; i < 8; i++) begin
            frame = 1'b1;
            check($sformatf("flash_f%0d", i + 1), flash, int'(FLASH_SEQ[7-i]));
            tick();
            frame = 1'b0;
            tick();
        end
        press_btn();
        check("over_idle_state", state, 0);
        check("over_idle_flash", flash, 0);

        // Held overlap counts once; a second rise counts again.
        press_btn();
        check("r2_state", state, 1);
        inc_count = 0;
        caught = 1'b1; tick(50);
        caught = 1'b0; tick();
        caught = 1'b1; tick();
        check("held_inc_pulse", score_inc, 1);
        caught = 1'b0; tick();
        check("held_score", score, 2);
        check("held_inc_count", inc_count, 2);

        // Three more catches reach MAX_SCORE inside the first second.
        catch_once();
        catch_once();
        caught = 1'b1; tick();
        check("max_score", score, 5);
        check("max_state", state, 2);
        check("max_time", time_left, 3);
        caught = 1'b0; tick();
        catch_once();
        check("max_sixth_score", score, 5);
        check("max_inc_count", inc_count, 5);

        // Score holds through IDLE and clears on the next PLAY entry.
        press_btn();
        check("idle_state", state, 0);
        check("idle_flash", flash, 0);
        check("idle_score_hold", score, 5);
        press_btn();
        check("r3_score_clear", score, 0);
        check("r3_state", state, 1);

        // Catch on the same cycle as the final frame pulse.
        pulse_frames(11);
        inc_count = 0;
        frame  = 1'b1;
        caught = 1'b1;
        tick();
        frame  = 1'b0;
        caught = 1'b0;
        check("last_score", score, 1);
        check("last_state", state, 2);
        check("last_time", time_left, 0);
        tick();
        check("last_inc_count", inc_count, 1);

        // Reset mid-round with button and overlap held high.
        press_btn();
        press_btn();
        check("r4_state", state, 1);
        catch_once();
        inc_count = 0;
        btnC   = 1'b1;
        caught = 1'b1;
        tick();
        greset_n = 1'b0;
        #2;
        check("mid_rst_state", state, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_inc", score_inc, 0);
        tick(2);
        greset_n = 1'b1;
        tick(5);
        check("post_rst_state", state, 0);
        check("post_rst_inc_count", inc_count, 0);
        btnC = 1'b0; tick();
        check("post_rst_still_idle", state, 0);
        btnC = 1'b1; tick();
        check("post_rst_play", state, 1);
        tick(3);
        check("post_rst_no_catch", score, 0);
        check("post_rst_inc_total", inc_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
